// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline register.
//   pipe_occ_e       : occupancy of a stage (empty, one beat, two beats)
//   PIPE_CTRL_W_DEF  : default width of the one-shot control strobe bundle
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } pipe_occ_e;

  localparam int PIPE_CTRL_W_DEF = 2;

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage entry of a pipeline stage: a W-bit register with load enable.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset, clears the entry to zero
//   i_load : capture i_d on the next rising edge
//   i_d    : entry input (payload and strobes concatenated)
//   o_q    : entry contents
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int W = 98
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and one-shot control strobes.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : upstream handshake
//   in_data/in_ctrl      : upstream payload and one-shot strobes
//   stall_i              : global stall, blocks downstream transfer
//   flush_i              : drop all held beats and the beat taken this cycle
//   out_valid/out_ready  : downstream handshake
//   out_data/out_ctrl    : head payload and its strobes (asserted once per entry)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = PIPE_CTRL_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  localparam int EW = DATA_W + CTRL_W;

  pipe_occ_e     r_occ;
  pipe_occ_e     w_occ_nxt;
  logic          r_fresh;
  logic          w_take;
  logic          w_give;
  logic          w_load_main;
  logic          w_main_from_skid;
  logic          w_load_skid;
  logic [EW-1:0] w_in_ent;
  logic [EW-1:0] w_main_d;
  logic [EW-1:0] w_main_q;
  logic [EW-1:0] w_skid_q;

  assign w_in_ent  = {in_data, in_ctrl};
  assign out_valid = (r_occ != OCC_EMPTY);
  assign w_take    = in_valid & in_ready;
  assign w_give    = out_valid & out_ready & ~stall_i;

  // Next occupancy and entry load controls. The main register always holds
  // the head; the skid register only ever holds the second-oldest beat.
  always_comb begin
    w_occ_nxt        = r_occ;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_take) begin
            w_occ_nxt   = OCC_ONE;
            w_load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_take && w_give) begin
            w_load_main = 1'b1;
          end else if (w_take) begin
            // Only reachable with a skid register: in_ready=0 otherwise.
            w_occ_nxt   = OCC_TWO;
            w_load_skid = 1'b1;
          end else if (w_give) begin
            w_occ_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_give) begin
            w_occ_nxt        = OCC_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy state and one-shot qualifier. fresh marks a head entry whose
  // strobes have not yet been presented in a cycle that failed to transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ   <= OCC_EMPTY;
      r_fresh <= 1'b0;
    end else begin
      r_occ <= w_occ_nxt;
      if (flush_i) begin
        r_fresh <= 1'b0;
      end else if (w_load_main) begin
        r_fresh <= 1'b1;
      end else if (out_valid && !w_give) begin
        r_fresh <= 1'b0;
      end
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_ent;

  pipe_stage_entry #(.W(EW)) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load_main),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  generate
    if (SKID == 1) begin : g_skid
      logic r_in_ready;

      pipe_stage_entry #(.W(EW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_skid),
        .i_d    (w_in_ent),
        .o_q    (w_skid_q)
      );

      // Registered ready: look ahead at next occupancy so it is exact.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_occ_nxt != OCC_TWO);
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_skid_q = '0;
      assign in_ready = ~out_valid | w_give;
    end
  endgenerate

  assign out_data = w_main_q[EW-1:CTRL_W];
  assign out_ctrl = w_main_q[CTRL_W-1:0] & {CTRL_W{r_fresh & out_valid}};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one instance with a skid buffer (index 0) and
// one without (index 1) share the same stimulus. Each has its own reference
// model: a bounded FIFO of accepted beats plus a "strobes not yet shown" flag.
module tb_pipe_stage_skid;

  typedef struct {
    logic [95:0] d;
    logic [1:0]  c;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [95:0] in_data = '0;
  logic [1:0]  in_ctrl = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir [2];
  logic        ov [2];
  logic [95:0] od [2];
  logic [1:0]  oc [2];

  int nvec = 0;
  int nerr = 0;

  beat_t mq [2][$];
  logic  mfresh [2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(96), .CTRL_W(2), .SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall_i(stall), .flush_i(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0])
  );

  pipe_stage_skid #(.DATA_W(96), .CTRL_W(2), .SKID(0)) u_dut_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .stall_i(stall), .flush_i(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1])
  );

  task automatic chk(input string name, input int k, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[skid=%0d] t=%0t got=%h want=%h", name, (k == 0), $time, act, exp);
    end
  endtask

  // Monitor + model: inputs are stable at the falling edge; compare, then
  // advance the model by the upcoming rising edge.
  always @(negedge clk) begin
    logic       eov, eir, g, t, lm;
    logic [1:0] eoc;
    beat_t      b;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("rst_ov", k, ov[k], 1'b0);
        chk("rst_oc", k, oc[k], 2'b00);
        chk("rst_ir", k, ir[k], 1'b1);
        chk("rst_od", k, od[k], 96'h0);
        mq[k].delete();
        mfresh[k] = 1'b0;
      end else begin
        eov = (mq[k].size() > 0);
        g   = eov && out_ready && !stall;
        eir = (k == 0) ? (mq[k].size() < 2) : (mq[k].size() == 0 || g);
        eoc = (eov && mfresh[k]) ? mq[k][0].c : 2'b00;
        chk("in_ready", k, ir[k], eir);
        chk("out_valid", k, ov[k], eov);
        chk("out_ctrl", k, oc[k], eoc);
        if (eov) chk("out_data", k, od[k], mq[k][0].d);
        t = in_valid && eir;
        if (flush) begin
          mq[k].delete();
          mfresh[k] = 1'b0;
        end else begin
          lm = 1'b0;
          if (g) begin
            void'(mq[k].pop_front());
            lm = (mq[k].size() > 0);
          end
          if (t) begin
            if (mq[k].size() == 0) lm = 1'b1;
            b.d = in_data;
            b.c = in_ctrl;
            mq[k].push_back(b);
          end
          if (lm) mfresh[k] = 1'b1;
          else if (eov && !g) mfresh[k] = 1'b0;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [95:0] d, input logic [1:0] c,
                      input logic ordy, input logic stl, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single beat straight through
    step(1'b1, 96'hA5, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("s1_ov", k, ov[k], 1'b1);
      chk("s1_od", k, od[k], 96'hA5);
      chk("s1_oc", k, oc[k], 2'b01);
    end
    step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) chk("s1_empty", k, ov[k], 1'b0);

    // 2: held entry shows its strobe once
    step(1'b1, 96'hA5, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 96'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("s2_oc", k, oc[k], 2'b00);
      chk("s2_od", k, od[k], 96'hA5);
    end
    repeat (3) step(1'b0, 96'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);

    // 3: fill the skid, then release
    step(1'b1, 96'h1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h2, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("s3_ir", 0, ir[0], 1'b0);
    repeat (3) step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);

    // 4: stall with downstream ready
    for (int i = 0; i < 3; i++) step(1'b1, 96'h10 + i, 2'b01, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);

    // 5: flush while full with an incoming beat
    step(1'b1, 96'h7, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h8, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h9, 2'b11, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk("s5_ov", k, ov[k], 1'b0);
      chk("s5_ir", k, ir[k], 1'b1);
      chk("s5_oc", k, oc[k], 2'b00);
    end
    repeat (2) step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, {$urandom(), $urandom(), $urandom()},
           2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end

    // 6: async reset with a fresh held entry
    step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 96'h5A, 2'b11, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("s6_ov", k, ov[k], 1'b0);
      chk("s6_oc", k, oc[k], 2'b00);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) step(1'b0, 96'h0, 2'b00, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
